// File: rtl/led_bus_arbiter_if.sv
// Bus bundle between the two masters (core, sequencer), the arbiter and the LED register block.
// The arbiter connects through the slave modport; the master modport is the environment's view.
interface led_bus_arbiter_if;
    logic        m0_req_i;
    logic        m1_req_i;
    logic        m0_we_i;
    logic        m1_we_i;
    logic [31:0] m0_addr_i;
    logic [31:0] m1_addr_i;
    logic [31:0] m0_wdata_i;
    logic [31:0] m1_wdata_i;
    logic        m0_gnt_o;
    logic        m1_gnt_o;
    logic        m0_rvalid_o;
    logic        m1_rvalid_o;
    logic [31:0] m0_rdata_o;
    logic [31:0] m1_rdata_o;
    logic        m0_err_o;
    logic        m1_err_o;
    logic        req_o;
    logic        we_o;
    logic [31:0] addr_o;
    logic [31:0] wdata_o;
    logic [31:0] rdata_i;

    modport slave (
        input  m0_req_i, m1_req_i, m0_we_i, m1_we_i,
        input  m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i, rdata_i,
        output m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o,
        output m0_rdata_o, m1_rdata_o, m0_err_o, m1_err_o,
        output req_o, we_o, addr_o, wdata_o
    );

    modport master (
        output m0_req_i, m1_req_i, m0_we_i, m1_we_i,
        output m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i, rdata_i,
        input  m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o,
        input  m0_rdata_o, m1_rdata_o, m0_err_o, m1_err_o,
        input  req_o, we_o, addr_o, wdata_o
    );
endinterface

// File: rtl/led_bus_arbiter.sv
// Two-master arbiter in front of the LED register block; fixed m0 priority by default,
// round-robin between simultaneous requesters when LED_ARB_ROUND_ROBIN_EN is defined.
//
// state | meaning
// IDLE  | wait for a request; previous access's rvalid pulse appears here
// ISSUE | grant pulse to the winner, slave request (held off on decode error)
// RESP  | slave data (or 0 on decode error) captured into the winner's rdata
module led_bus_arbiter (
    input logic              CLK100,
    input logic              reset,
    led_bus_arbiter_if.slave bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        win_q, win_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        dec_err_q, dec_err_d;
    logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic        rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic        err0_q, err0_d, err1_q, err1_d;
    logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic        any_req;
    logic        pick_m1;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        issue;

    assign any_req = bus.m0_req_i | bus.m1_req_i;

`ifdef LED_ARB_ROUND_ROBIN_EN
    // ptr_q = 1 means m0 won last, so m1 is favoured on a tie
    logic ptr_q, ptr_d;

    assign pick_m1 = bus.m1_req_i & (~bus.m0_req_i | ptr_q);

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == ST_IDLE && any_req) ptr_d = ~pick_m1;
    end

    always_ff @(posedge CLK100 or posedge reset) begin
        if (reset) ptr_q <= 1'b0;
        else       ptr_q <= ptr_d;
    end
`else
    assign pick_m1 = bus.m1_req_i & ~bus.m0_req_i;
`endif

    assign sel_we    = pick_m1 ? bus.m1_we_i    : bus.m0_we_i;
    assign sel_addr  = pick_m1 ? bus.m1_addr_i  : bus.m0_addr_i;
    assign sel_wdata = pick_m1 ? bus.m1_wdata_i : bus.m0_wdata_i;

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        dec_err_d = dec_err_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        err0_d    = 1'b0;
        err1_d    = 1'b0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d   = ST_ISSUE;
                    win_d     = pick_m1;
                    we_d      = sel_we;
                    addr_d    = sel_addr;
                    wdata_d   = sel_wdata;
                    dec_err_d = !((sel_addr[11:0] == 12'h800) || (sel_addr[11:0] == 12'hF00));
                    gnt0_d    = ~pick_m1;
                    gnt1_d    = pick_m1;
                end
            end
            ST_ISSUE: state_d = ST_RESP;
            ST_RESP: begin
                // undecodable accesses keep the same latency but return 0 with err
                state_d = ST_IDLE;
                if (win_q) begin
                    rvalid1_d = 1'b1;
                    err1_d    = dec_err_q;
                    rdata1_d  = dec_err_q ? 32'h0 : bus.rdata_i;
                end else begin
                    rvalid0_d = 1'b1;
                    err0_d    = dec_err_q;
                    rdata0_d  = dec_err_q ? 32'h0 : bus.rdata_i;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK100 or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            win_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            dec_err_q <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= 32'h0;
            rdata1_q  <= 32'h0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            dec_err_q <= dec_err_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    // slave-side fields are forced to 0 whenever no request is being issued
    assign issue       = (state_q == ST_ISSUE) & ~dec_err_q;
    assign bus.req_o   = issue;
    assign bus.we_o    = issue & we_q;
    assign bus.addr_o  = issue ? addr_q : 32'h0;
    assign bus.wdata_o = issue ? wdata_q : 32'h0;

    assign bus.m0_gnt_o    = gnt0_q;
    assign bus.m1_gnt_o    = gnt1_q;
    assign bus.m0_rvalid_o = rvalid0_q;
    assign bus.m1_rvalid_o = rvalid1_q;
    assign bus.m0_err_o    = err0_q;
    assign bus.m1_err_o    = err1_q;
    assign bus.m0_rdata_o  = rdata0_q;
    assign bus.m1_rdata_o  = rdata1_q;
endmodule

// File: tb/tb_led_bus_arbiter.sv
// Bench for led_bus_arbiter: transaction-level model plus directed literal checks and random traffic.
// Expected arbitration follows LED_ARB_ROUND_ROBIN_EN the same way the design does.
module tb_led_bus_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    led_bus_arbiter_if bus ();
    led_bus_arbiter dut (.CLK100(clk), .reset(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    // LED register block stand-in: two registers, read data registered one cycle after req_o
    logic [31:0] slv_reg [2] = '{32'h0, 32'h5};
    logic        s_req = 1'b0;
    logic        s_we = 1'b0;
    logic [31:0] s_addr = 32'h0;
    logic [31:0] s_wdata = 32'h0;

    always @(negedge clk) begin
        s_req   <= bus.req_o;
        s_we    <= bus.we_o;
        s_addr  <= bus.addr_o;
        s_wdata <= bus.wdata_o;
    end

    always @(posedge clk) begin
        if (s_req) begin
            bus.rdata_i <= slv_reg[(s_addr[11:0] == 12'hF00) ? 1 : 0];
            if (s_we) slv_reg[(s_addr[11:0] == 12'hF00) ? 1 : 0] <= s_wdata;
        end else begin
            bus.rdata_i <= $urandom;
        end
    end

    // transaction-level model: an access sampled at cycle t0 grants at t0+1 and completes at t0+3
    int          cyc = 0;
    bit          txn = 1'b0;
    int          t0 = 0;
    bit          m_win, m_err, m_we;
    logic [31:0] m_addr, m_wdata, m_exp;
    logic [31:0] m_hold [2];
    logic [31:0] m_reg [2] = '{32'h0, 32'h5};
`ifdef LED_ARB_ROUND_ROBIN_EN
    int          last_win = 1;
`endif

    task automatic model_reset();
        txn       = 1'b0;
        m_hold[0] = 32'h0;
        m_hold[1] = 32'h0;
`ifdef LED_ARB_ROUND_ROBIN_EN
        last_win  = 1;
`endif
    endtask

    task automatic model_step();
        int c = cyc;
        bit r0 = bus.m0_req_i;
        bit r1 = bus.m1_req_i;
        int w;
        int idx;
        if ((!txn || c >= t0 + 3) && (r0 || r1)) begin
            if (r0 && r1) begin
`ifdef LED_ARB_ROUND_ROBIN_EN
                w = (last_win == 0) ? 1 : 0;
`else
                w = 0;
`endif
            end else begin
                w = r1 ? 1 : 0;
            end
`ifdef LED_ARB_ROUND_ROBIN_EN
            last_win = w;
`endif
            txn     = 1'b1;
            t0      = c;
            m_win   = (w == 1);
            m_we    = m_win ? bus.m1_we_i : bus.m0_we_i;
            m_addr  = m_win ? bus.m1_addr_i : bus.m0_addr_i;
            m_wdata = m_win ? bus.m1_wdata_i : bus.m0_wdata_i;
            m_err   = !((m_addr[11:0] == 12'h800) || (m_addr[11:0] == 12'hF00));
            if (m_err) begin
                m_exp = 32'h0;
            end else begin
                idx   = (m_addr[11:0] == 12'hF00) ? 1 : 0;
                m_exp = m_reg[idx];
                if (m_we) m_reg[idx] = m_wdata;
            end
        end
        cyc = c + 1;
        if (txn && cyc == t0 + 3) m_hold[m_win ? 1 : 0] = m_exp;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare_all();
        bit g  = txn && (cyc == t0 + 1);
        bit rv = txn && (cyc == t0 + 3);
        bit rq = g && !m_err;
        chk("m0_gnt",    32'(bus.m0_gnt_o),    32'(g && !m_win));
        chk("m1_gnt",    32'(bus.m1_gnt_o),    32'(g && m_win));
        chk("m0_rvalid", 32'(bus.m0_rvalid_o), 32'(rv && !m_win));
        chk("m1_rvalid", 32'(bus.m1_rvalid_o), 32'(rv && m_win));
        chk("m0_err",    32'(bus.m0_err_o),    32'(rv && !m_win && m_err));
        chk("m1_err",    32'(bus.m1_err_o),    32'(rv && m_win && m_err));
        chk("m0_rdata",  bus.m0_rdata_o,       m_hold[0]);
        chk("m1_rdata",  bus.m1_rdata_o,       m_hold[1]);
        chk("req_o",     32'(bus.req_o),       32'(rq));
        chk("we_o",      32'(bus.we_o),        32'(rq && m_we));
        chk("addr_o",    bus.addr_o,           rq ? m_addr : 32'h0);
        chk("wdata_o",   bus.wdata_o,          rq ? m_wdata : 32'h0);
    endtask

    // master behaviour: hold req until gnt is seen, drop it for at least one cycle afterwards
    bit          pend [2];
    bit          gl [2];
    logic        we_p [2];
    logic [31:0] addr_p [2];
    logic [31:0] wd_p [2];
    bit          auto_en = 1'b0;
    bit          cont_en = 1'b0;
    bit          log_en = 1'b0;
    int          g_who [$];
    int          g_cyc [$];

    task automatic gen(int m);
        int          r = $urandom_range(0, 3);
        logic [31:0] a = $urandom;
        case (r)
            0:       a[11:0] = 12'h800;
            1:       a[11:0] = 12'hF00;
            2:       a = 32'h0000_0800;
            default: ;
        endcase
        we_p[m]   = ($urandom_range(0, 1) == 1);
        addr_p[m] = a;
        wd_p[m]   = $urandom;
    endtask

    task automatic set_req(int m, logic we, logic [31:0] a, logic [31:0] wd);
        pend[m]   = 1'b1;
        we_p[m]   = we;
        addr_p[m] = a;
        wd_p[m]   = wd;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) cyc++;
        else     model_step();
        #1;
        for (int m = 0; m < 2; m++) begin
            if (gl[m]) begin
                pend[m] = 1'b0;
            end else if (!pend[m] && (cont_en || (auto_en && $urandom_range(0, 2) == 0))) begin
                pend[m] = 1'b1;
                gen(m);
            end
            if (!pend[m]) gen(m);
        end
        bus.m0_req_i   = pend[0];
        bus.m0_we_i    = we_p[0];
        bus.m0_addr_i  = addr_p[0];
        bus.m0_wdata_i = wd_p[0];
        bus.m1_req_i   = pend[1];
        bus.m1_we_i    = we_p[1];
        bus.m1_addr_i  = addr_p[1];
        bus.m1_wdata_i = wd_p[1];
        @(negedge clk);
        gl[0] = bus.m0_gnt_o;
        gl[1] = bus.m1_gnt_o;
        if (log_en && bus.m0_gnt_o) begin g_who.push_back(0); g_cyc.push_back(cyc); end
        if (log_en && bus.m1_gnt_o) begin g_who.push_back(1); g_cyc.push_back(cyc); end
        compare_all();
    endtask

    int seen;
    int exp_w [4];

    initial begin
        rst = 1'b1;
        for (int m = 0; m < 2; m++) begin
            pend[m] = 1'b0; gl[m] = 1'b0; we_p[m] = 1'b0; addr_p[m] = 32'h0; wd_p[m] = 32'h0;
        end
        bus.m0_req_i = 1'b0; bus.m0_we_i = 1'b0; bus.m0_addr_i = 32'h0; bus.m0_wdata_i = 32'h0;
        bus.m1_req_i = 1'b0; bus.m1_we_i = 1'b0; bus.m1_addr_i = 32'h0; bus.m1_wdata_i = 32'h0;
        model_reset();
        repeat (3) cycle();
        chk("rst_m0_gnt", 32'(bus.m0_gnt_o), 32'h0);
        chk("rst_req_o", 32'(bus.req_o), 32'h0);
        chk("rst_m1_rdata", bus.m1_rdata_o, 32'h0);

        // m0 write 0xFF to 0x800, request already up when reset releases
        set_req(0, 1'b1, 32'h0000_0800, 32'h0000_00FF);
        cycle();
        rst = 1'b0;
        cycle();
        chk("wr_m0_gnt", 32'(bus.m0_gnt_o), 32'h1);
        chk("wr_req_o", 32'(bus.req_o), 32'h1);
        chk("wr_we_o", 32'(bus.we_o), 32'h1);
        chk("wr_addr_o", bus.addr_o, 32'h0000_0800);
        chk("wr_wdata_o", bus.wdata_o, 32'h0000_00FF);
        cycle(); cycle();
        chk("wr_m0_rvalid", 32'(bus.m0_rvalid_o), 32'h1);
        chk("wr_m0_err", 32'(bus.m0_err_o), 32'h0);
        chk("wr_m0_rdata_prewrite", bus.m0_rdata_o, 32'h0);

        // m1 read 0xF00, register holds 5
        set_req(1, 1'b0, 32'h0000_0F00, 32'h0);
        cycle(); cycle();
        chk("rd_m1_gnt", 32'(bus.m1_gnt_o), 32'h1);
        chk("rd_m0_gnt", 32'(bus.m0_gnt_o), 32'h0);
        cycle(); cycle();
        chk("rd_m1_rvalid", 32'(bus.m1_rvalid_o), 32'h1);
        chk("rd_m1_rdata", bus.m1_rdata_o, 32'h5);
        chk("rd_m0_rvalid", 32'(bus.m0_rvalid_o), 32'h0);

        // undecodable address: no slave request, err with zero data
        set_req(0, 1'b0, 32'h0000_0123, 32'h0);
        seen = 0;
        repeat (4) begin cycle(); if (bus.req_o) seen++; end
        chk("bad_req_o_count", 32'(seen), 32'h0);
        chk("bad_m0_rvalid", 32'(bus.m0_rvalid_o), 32'h1);
        chk("bad_m0_err", 32'(bus.m0_err_o), 32'h1);
        chk("bad_m0_rdata", bus.m0_rdata_o, 32'h0);

        // m0 read 0x800 returns the earlier write
        set_req(0, 1'b0, 32'h0000_0800, 32'h0);
        repeat (4) cycle();
        chk("rd800_m0_rdata", bus.m0_rdata_o, 32'h0000_00FF);

        // reset during RESP of an m0 read
        set_req(0, 1'b0, 32'h0000_0800, 32'h0);
        repeat (3) cycle();
        rst = 1'b1;
        model_reset();
        #1;
        chk("abort_m0_rdata", bus.m0_rdata_o, 32'h0);
        chk("abort_m0_gnt", 32'(bus.m0_gnt_o), 32'h0);
        chk("abort_req_o", 32'(bus.req_o), 32'h0);
        chk("abort_m0_rvalid", 32'(bus.m0_rvalid_o), 32'h0);
        cycle(); cycle();
        rst = 1'b0;
        seen = 0;
        repeat (4) begin cycle(); if (bus.m0_rvalid_o) seen++; end
        chk("abort_no_rvalid", 32'(seen), 32'h0);
        set_req(1, 1'b0, 32'h0000_0F00, 32'h0);
        cycle(); cycle();
        chk("after_m1_gnt", 32'(bus.m1_gnt_o), 32'h1);
        cycle(); cycle();
        chk("after_m1_rvalid", 32'(bus.m1_rvalid_o), 32'h1);
        chk("after_m1_rdata", bus.m1_rdata_o, 32'h5);

        // both masters requesting back to back
`ifdef LED_ARB_ROUND_ROBIN_EN
        exp_w = '{0, 1, 0, 1};
`else
        exp_w = '{0, 0, 0, 0};
`endif
        cont_en = 1'b1;
        log_en  = 1'b1;
        repeat (13) cycle();
        log_en  = 1'b0;
        cont_en = 1'b0;
        chk("seq_grant_count", 32'(g_who.size()), 32'd4);
        for (int i = 0; i < 4 && i < g_who.size(); i++) begin
            chk("seq_winner", 32'(g_who[i]), 32'(exp_w[i]));
            if (i > 0) chk("seq_spacing", 32'(g_cyc[i] - g_cyc[i-1]), 32'd3);
        end
        repeat (12) cycle();

        auto_en = 1'b1;
        repeat (2000) cycle();
        auto_en = 1'b0;
        repeat (12) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/led_bus_arbiter.md
LED_BUS_ARBITER -- requirements
Module: led_bus_arbiter

Interface
REQ-001 SHALL have port CLK100  input  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ports m0_req_i, m1_req_i  input  1 each  access request from master 0 (core) and master 1 (sequencer).
REQ-004 SHALL have ports m0_we_i, m1_we_i  input  1 each  1 = write, 0 = read.
REQ-005 SHALL have ports m0_addr_i, m1_addr_i  input  32 each  byte address; only bits [11:0] are decoded.
REQ-006 SHALL have ports m0_wdata_i, m1_wdata_i  input  32 each  write data.
REQ-007 SHALL have ports m0_gnt_o, m1_gnt_o  output  1 each  one-cycle grant pulse.
REQ-008 SHALL have ports m0_rvalid_o, m1_rvalid_o  output  1 each  one-cycle completion pulse.
REQ-009 SHALL have ports m0_rdata_o, m1_rdata_o  output  32 each  read data, valid with rvalid.
REQ-010 SHALL have ports m0_err_o, m1_err_o  output  1 each  decode error, valid with rvalid.
REQ-011 SHALL have ports req_o, we_o  output  1 each, addr_o  output  32, wdata_o  output  32  slave-side request to the LED register block.
REQ-012 SHALL have port rdata_i  input  32  slave read data, registered by the slave one cycle after req_o.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, RESP, with ISSUE and RESP each lasting exactly one cycle.
REQ-014 In IDLE with any request high, SHALL select a winner, latch its we/addr/wdata, assert that master's gnt in the next cycle and enter ISSUE.
REQ-015 In IDLE with no request, SHALL remain in IDLE with all pulse outputs low.
REQ-016 Simultaneous m0/m1 requests SHALL grant the master not granted most recently; the priority pointer resets to favour m0.
REQ-017 A single requester SHALL always be granted, regardless of the pointer.
REQ-018 In ISSUE, SHALL drive req_o=1 and we_o/addr_o/wdata_o from the latched values for exactly that cycle; req_o SHALL be 0 in every other state.
REQ-019 Decodable addresses (addr[11:0] = 0x800 or 0xF00) SHALL go through ISSUE.
REQ-020 Other addresses SHALL skip the slave access: req_o stays 0, rdata=0 and err=1 are returned with rvalid.
REQ-021 In RESP, SHALL register rdata_i into the winner's rdata and pulse its rvalid in the following cycle (the IDLE cycle).
REQ-022 Writes SHALL also return rvalid; rdata then carries the slave's pre-write register value.
REQ-023 Latency SHALL be: req sampled in cycle 0; gnt and req_o in cycle 1; RESP in cycle 2; rvalid in cycle 3.
REQ-024 A new arbitration SHALL be allowed in the same cycle that rvalid is high.
REQ-025 Requests SHALL be ignored in ISSUE and RESP; masters SHALL hold req until gnt and drop it after.
REQ-026 The non-winning master's rvalid/gnt/err SHALL stay 0; its rdata SHALL hold its last value.

Reset
REQ-027 Asserting reset SHALL immediately force IDLE; req_o, gnt, rvalid and err to 0; rdata, addr_o, wdata_o and we_o to 0; and the pointer to favour m0.
REQ-028 Reset mid-transaction (ISSUE or RESP) SHALL abort the transaction with no rvalid emitted after release.
REQ-029 The first arbitration SHALL occur on the first rising edge after reset deasserts.

Configuration
REQ-030 With macro LED_ARB_ROUND_ROBIN_EN defined, SHALL use round-robin arbitration per REQ-016.
REQ-031 Without LED_ARB_ROUND_ROBIN_EN, SHALL use fixed priority: m0 always wins simultaneous requests and the pointer logic is absent.

Verification
REQ-032 m0 write 0x0000_00FF to 0x800 -> m0_gnt in cycle 1; req_o=1, we_o=1, addr_o=0x800 in cycle 1; m0_rvalid=1, m0_err=0 in cycle 3.
REQ-033 m1 read 0xF00 with slave rdata_i=0x0000_0005 in cycle 2 -> m1_rdata=0x5, m1_rvalid=1 in cycle 3; m0 outputs stay 0.
REQ-034 Both masters request continuously, round-robin enabled -> grants alternate m0, m1, m0, m1 every 3 cycles.
REQ-035 Same as REQ-034 with the macro undefined -> m0 granted every time; m1 is never granted while m0 requests.
REQ-036 m0 read at 0x123 -> req_o never asserts; m0_rvalid=1, m0_err=1, m0_rdata=0 in cycle 3.
REQ-037 Reset pulsed in cycle 2 of an m0 read -> outputs 0 immediately; no m0_rvalid follows; next m1 request is granted normally.
